// File: rtl/sonar_pkg.sv
// Shared constants and types for the sonar obstacle detector.
// Holds the ticks-to-mm scaling constants, the controller state type and
// the channel index type, plus a helper that turns the scaled product into mm.
package sonar_pkg;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned TICK_W    = 20;
  localparam int unsigned MM_W      = 12;
  localparam int unsigned ACC_W     = 28;

  // mm = ticks * MM_MULT / 2^MM_SHIFT
  localparam int unsigned MM_MULT   = 223;
  localparam int unsigned MM_SHIFT  = 16;
  localparam int unsigned MULT_BITS = 8;
  localparam int unsigned MM_MAX    = 4095;

  localparam int unsigned BIT_CNT_W = $clog2(MULT_BITS);

  localparam logic [MULT_BITS-1:0] MM_MULT_VEC = MULT_BITS'(MM_MULT);
  localparam logic [MM_W-1:0]      MM_MAX_MM   = MM_W'(MM_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    FILTER = 2'd2,
    UPDATE = 2'd3
  } state_e;

  typedef logic [1:0] chan_t;

  // Scale the finished product down to mm, clamping to the largest code.
  function automatic logic [MM_W-1:0] acc_to_mm(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] scaled;
    logic [MM_W-1:0]  result;
    scaled = acc >> MM_SHIFT;
    if (scaled > ACC_W'(MM_MAX)) begin
      result = MM_MAX_MM;
    end else begin
      result = scaled[MM_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/median3.sv
// Combinational median of three unsigned distances.
// Ports:
//   a, b, c : three 12-bit distances in mm
//   med     : the middle value of the three
module median3
  import sonar_pkg::*;
(
  input  logic [MM_W-1:0] a,
  input  logic [MM_W-1:0] b,
  input  logic [MM_W-1:0] c,
  output logic [MM_W-1:0] med
);

  logic [MM_W-1:0] lo_ab;
  logic [MM_W-1:0] hi_ab;
  logic [MM_W-1:0] hi_min_c;

  // median = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo_ab    = (a < b) ? a : b;
    hi_ab    = (a < b) ? b : a;
    hi_min_c = (hi_ab < c) ? hi_ab : c;
    med      = (lo_ab > hi_min_c) ? lo_ab : hi_min_c;
  end

endmodule

// File: rtl/sonar_obstacle.sv
// Three-channel sonar obstacle detector.
// Each trigger rising edge captures the matching echo width; a single shared
// shift-add multiplier converts ticks to mm, a 3-deep per-channel history is
// median-filtered, and the obstacle flag is updated with hysteresis.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   T1, T2, T3      : trigger lines used as sample strobes
//                     (T2 -> R1, T3 -> R2, T1 -> R3)
//   R1, R2, R3      : echo widths in clock ticks
//   D1, D2, D3      : median-filtered distance per sonar in mm
//   obstacle        : per-sonar obstacle flag, bit0 = sonar 1
//   valid           : one-cycle pulse when a channel update completes
//   ch              : channel index of the last update
module sonar_obstacle
  import sonar_pkg::*;
#(
  parameter logic [MM_W-1:0]   THRESH_MM    = 12'd300,
  parameter logic [MM_W-1:0]   HYST_MM      = 12'd50,
  parameter logic [TICK_W-1:0] NOECHO_TICKS = 20'd880000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              T1,
  input  logic              T2,
  input  logic              T3,
  input  logic [TICK_W-1:0] R1,
  input  logic [TICK_W-1:0] R2,
  input  logic [TICK_W-1:0] R3,
  output logic [MM_W-1:0]   D1,
  output logic [MM_W-1:0]   D2,
  output logic [MM_W-1:0]   D3,
  output logic [2:0]        obstacle,
  output logic              valid,
  output logic [1:0]        ch
);

  // Clear level widened by one bit so THRESH_MM + HYST_MM cannot wrap.
  localparam logic [MM_W:0] CLEAR_MM = {1'b0, THRESH_MM} + {1'b0, HYST_MM};

  // Strobe capture
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] rise;
  logic [TICK_W-1:0] raw      [NUM_CH];
  logic [TICK_W-1:0] sample_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_clr;

  // Controller and shared multiplier
  state_e                 state_q;
  state_e                 state_d;
  chan_t                  pick;
  logic                   start;
  chan_t                  cur_q;
  logic [TICK_W-1:0]      op_q;
  logic                   noecho_q;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       addend;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [MM_W-1:0]        mm_new;

  // Filter and outputs; hist_q[c][0] is the newest entry
  logic [MM_W-1:0]   hist_q [NUM_CH][3];
  logic [MM_W-1:0]   d_q    [NUM_CH];
  logic [MM_W-1:0]   med_a;
  logic [MM_W-1:0]   med_b;
  logic [MM_W-1:0]   med_c;
  logic [MM_W-1:0]   med;
  logic [NUM_CH-1:0] obst_q;
  logic              valid_q;
  chan_t             ch_q;

  assign trig   = {T1, T3, T2};
  assign rise   = trig & ~trig_q;

  always_comb begin
    raw[0] = R1;
    raw[1] = R2;
    raw[2] = R3;
  end

  // Lowest-index pending channel wins.
  always_comb begin
    pick = 2'd0;
    if (!pend_q[0]) begin
      pick = pend_q[1] ? 2'd1 : 2'd2;
    end
  end

  assign start    = (state_q == IDLE) && (|pend_q);
  assign pend_clr = start ? (3'b001 << pick) : 3'b000;

  // A new strobe on the channel being dequeued re-arms it, so set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q <= '0;
      pend_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sample_q[c] <= '0;
      end
    end else begin
      trig_q <= trig;
      pend_q <= (pend_q & ~pend_clr) | rise;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rise[c]) begin
          sample_q[c] <= raw[c];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (|pend_q) state_d = MULT;
      MULT:   if (bit_cnt_q == '0) state_d = FILTER;
      FILTER: state_d = UPDATE;
      UPDATE: state_d = IDLE;
    endcase
  end

  // MSB-first shift-add: acc = 2*acc + bit*ticks, one multiplier bit per cycle.
  assign addend = MM_MULT_VEC[bit_cnt_q] ? ACC_W'(op_q) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      op_q      <= '0;
      noecho_q  <= 1'b0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cur_q     <= pick;
        op_q      <= sample_q[pick];
        noecho_q  <= (sample_q[pick] >= NOECHO_TICKS);
        acc_q     <= '0;
        bit_cnt_q <= BIT_CNT_W'(MULT_BITS - 1);
      end else if (state_q == MULT) begin
        // No-echo samples still spend the full multiply time to keep latency fixed.
        if (!noecho_q) begin
          acc_q <= {acc_q[ACC_W-2:0], 1'b0} + addend;
        end
        bit_cnt_q <= bit_cnt_q - 1'b1;
      end
    end
  end

  assign mm_new = noecho_q ? MM_MAX_MM : acc_to_mm(acc_q);

  // Median inputs come from the current channel's history after the shift.
  always_comb begin
    med_a = hist_q[0][0];
    med_b = hist_q[0][1];
    med_c = hist_q[0][2];
    for (int c = 1; c < NUM_CH; c++) begin
      if (cur_q == chan_t'(c)) begin
        med_a = hist_q[c][0];
        med_b = hist_q[c][1];
        med_c = hist_q[c][2];
      end
    end
  end

  median3 u_median3 (
    .a   (med_a),
    .b   (med_b),
    .c   (med_c),
    .med (med)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int e = 0; e < 3; e++) begin
          hist_q[c][e] <= MM_MAX_MM;
        end
        d_q[c] <= MM_MAX_MM;
      end
      obst_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == FILTER) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (cur_q == chan_t'(c)) begin
            hist_q[c][2] <= hist_q[c][1];
            hist_q[c][1] <= hist_q[c][0];
            hist_q[c][0] <= mm_new;
          end
        end
      end
      if (state_q == UPDATE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (cur_q == chan_t'(c)) begin
            d_q[c] <= med;
            // Between the set and clear levels the flag holds.
            if (med < THRESH_MM) begin
              obst_q[c] <= 1'b1;
            end else if ({1'b0, med} >= CLEAR_MM) begin
              obst_q[c] <= 1'b0;
            end
          end
        end
        valid_q <= 1'b1;
        ch_q    <= cur_q;
      end
    end
  end

  assign D1       = d_q[0];
  assign D2       = d_q[1];
  assign D3       = d_q[2];
  assign obstacle = obst_q;
  assign valid    = valid_q;
  assign ch       = ch_q;

endmodule

// File: tb/tb_sonar_obstacle.sv
// Self-checking bench for sonar_obstacle: directed scenarios followed by
// randomized multi-channel strobes, compared against a behavioural model.
module tb_sonar_obstacle;

  logic        clk = 1'b0;
  logic        reset;
  logic        T1, T2, T3;
  logic [19:0] R1, R2, R3;
  logic [11:0] D1, D2, D3;
  logic [2:0]  obstacle;
  logic        valid;
  logic [1:0]  ch;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: per-channel history (index 0 newest) and flags.
  int         hist [3][3];
  logic [2:0] obst_m;

  sonar_obstacle dut (
    .clk      (clk),
    .reset    (reset),
    .T1       (T1),
    .T2       (T2),
    .T3       (T3),
    .R1       (R1),
    .R2       (R2),
    .R3       (R3),
    .D1       (D1),
    .D2       (D2),
    .D3       (D3),
    .obstacle (obstacle),
    .valid    (valid),
    .ch       (ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d expected<100000", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mm_of(input int t);
    longint p;
    if (t >= 880000) return 4095;
    p = (longint'(t) * 223) / 65536;
    return (p > 4095) ? 4095 : int'(p);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int e = 0; e < 3; e++) hist[c][e] = 4095;
    obst_m = 3'b000;
  endtask

  task automatic model_step(input int c, input int t, output int med);
    int q[$];
    hist[c][2] = hist[c][1];
    hist[c][1] = hist[c][0];
    hist[c][0] = mm_of(t);
    q = {hist[c][0], hist[c][1], hist[c][2]};
    q.sort();
    med = q[1];
    if (med < 300) obst_m[c] = 1'b1;
    else if (med >= 350) obst_m[c] = 1'b0;
  endtask

  task automatic set_trig(input int c, input logic v);
    case (c)
      0: T2 = v;
      1: T3 = v;
      default: T1 = v;
    endcase
  endtask

  task automatic set_r(input int c, input int t);
    case (c)
      0: R1 = 20'(t);
      1: R2 = 20'(t);
      default: R3 = 20'(t);
    endcase
  endtask

  function automatic logic [11:0] get_d(input int c);
    case (c)
      0: return D1;
      1: return D2;
      default: return D3;
    endcase
  endfunction

  task automatic wait_valid();
    int n = 0;
    while (valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (valid === 1'b1) cnt++;
    end
  endtask

  // Strobe every channel in mask on the same edge and check each update in turn.
  task automatic run_batch(input logic [2:0] mask, input int t0, input int t1, input int t2,
                           input string tag);
    int tv[3];
    int e, k, exp_d;
    tv = '{t0, t1, t2};
    for (int c = 0; c < 3; c++) begin
      if (mask[c]) begin
        set_r(c, tv[c]);
        set_trig(c, 1'b1);
      end
    end
    step();
    e = cyc;
    for (int c = 0; c < 3; c++) set_trig(c, 1'b0);
    k = 0;
    for (int c = 0; c < 3; c++) begin
      if (mask[c]) begin
        k++;
        model_step(c, tv[c], exp_d);
        wait_valid();
        check({tag, "_lat"}, cyc - e, 11 * k);
        check({tag, "_ch"}, ch, c);
        check({tag, "_d"}, get_d(c), exp_d);
        check({tag, "_obst"}, obstacle, obst_m);
        step();
        check({tag, "_pulse"}, valid, 0);
      end
    end
  endtask

  function automatic int pick_ticks();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(82000, 109000));
      1: return int'($urandom_range(0, 1048575));
      2: return int'($urandom_range(879990, 880010));
      default: return int'($urandom_range(0, 300000));
    endcase
  endfunction

  initial begin
    int e, d0, d1, cnt;
    logic [2:0] mask;

    reset = 1'b1;
    T1 = 1'b0; T2 = 1'b0; T3 = 1'b0;
    R1 = '0; R2 = '0; R3 = '0;
    model_reset();
    repeat (3) step();
    check("rst_d1", D1, 4095);
    check("rst_d2", D2, 4095);
    check("rst_d3", D3, 4095);
    check("rst_obst", obstacle, 0);
    check("rst_valid", valid, 0);
    check("rst_ch", ch, 0);
    reset = 1'b0;
    step();

    // 1000 mm on sonar 1: the first update still sees two 4095 entries.
    run_batch(3'b001, 294118, 0, 0, "r1_first");
    check("r1_first_const", D1, 4095);
    repeat (2) run_batch(3'b001, 294118, 0, 0, "r1_rep");
    check("r1_1000", D1, 1000);
    check("r1_obst", obstacle, 0);

    // 250 mm on sonar 2 sets the flag once it is the median.
    repeat (2) run_batch(3'b010, 0, 73529, 0, "r2_250");
    check("r2_250_d", D2, 250);
    check("r2_250_obst", obstacle[1], 1);

    // Hysteresis band: 300 mm holds, 350 mm clears once it is the median.
    repeat (3) run_batch(3'b010, 0, 88235, 0, "r2_300");
    check("r2_300_hold", obstacle[1], 1);
    run_batch(3'b010, 0, 102941, 0, "r2_350a");
    check("r2_350a_hold", obstacle[1], 1);
    run_batch(3'b010, 0, 102941, 0, "r2_350b");
    check("r2_350b_clear", obstacle[1], 0);
    run_batch(3'b010, 0, 102941, 0, "r2_350c");

    // Simultaneous strobes are served in index order.
    run_batch(3'b101, 20000, 0, 10000, "simul");
    check("simul_hist0", hist[0][0], mm_of(20000));

    // No-echo reading keeps the same latency.
    run_batch(3'b001, 900000, 0, 0, "noecho");

    // Busy strobes pend; a repeat on a pending channel overwrites its sample.
    R1 = 20'd150000; T2 = 1'b1;
    step();
    e = cyc;
    T2 = 1'b0;
    step();
    step();
    R2 = 20'd50000; T3 = 1'b1;
    step();
    T3 = 1'b0;
    step();
    R2 = 20'd80000; T3 = 1'b1;
    step();
    T3 = 1'b0;
    model_step(0, 150000, d0);
    model_step(1, 80000, d1);
    wait_valid();
    check("busy_lat0", cyc - e, 11);
    check("busy_ch0", ch, 0);
    check("busy_d1", D1, d0);
    step();
    wait_valid();
    check("busy_lat1", cyc - e, 22);
    check("busy_ch1", ch, 1);
    check("busy_d2", D2, d1);
    check("busy_obst", obstacle, obst_m);
    count_valids(30, cnt);
    check("busy_no_dup", cnt, 0);

    // Reset during the fifth multiply cycle aborts the update.
    R1 = 20'd200000; T2 = 1'b1;
    step();
    T2 = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("mrst_d1", D1, 4095);
    check("mrst_d2", D2, 4095);
    check("mrst_d3", D3, 4095);
    check("mrst_obst", obstacle, 0);
    check("mrst_valid", valid, 0);
    check("mrst_ch", ch, 0);
    count_valids(30, cnt);
    check("mrst_no_valid", cnt, 0);
    run_batch(3'b010, 0, 60000, 0, "post_rst");

    for (int i = 0; i < 20; i++) begin
      mask = 3'($urandom_range(1, 7));
      run_batch(mask, pick_ticks(), pick_ticks(), pick_ticks(), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
